// File: rtl/uop_decode_queue.sv
// rtl/uop_decode_queue.sv - ARM instruction decoder feeding a DEPTH-entry micro-op FIFO
module uop_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int MUL_EN = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic             flush_i,
    output logic             uop_valid_o,
    input  logic             uop_ready_i,
    output logic [63:0]      uop_o,
    output logic [CNT_W-1:0] count_o,
    output logic             illegal_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Micro-op field layout; bits not listed here are always zero.
    localparam int UOP_VALID_B     = 0;
    localparam int UOP_COND_LSB    = 1;   // 4 bits
    localparam int UOP_CLASS_LSB   = 5;   // 3 bits
    localparam int UOP_ITYPE_LSB   = 8;   // 3 bits
    localparam int UOP_SRC_0_LSB   = 11;  // 4 bits
    localparam int UOP_SRC_1_LSB   = 15;  // 4 bits
    localparam int UOP_SRC_2_LSB   = 19;  // 4 bits
    localparam int UOP_DST_0_LSB   = 23;  // 4 bits
    localparam int UOP_DST_0_VALID = 27;
    localparam int UOP_IMM_12_LSB  = 28;  // 12 bits

    localparam logic [2:0] CLASS_INTEGER   = 3'd1;
    localparam logic [2:0] CLASS_INTEGER_M = 3'd2;
    localparam logic [2:0] CLASS_LOAD      = 3'd3;
    localparam logic [2:0] CLASS_STORE     = 3'd4;

    localparam logic [2:0] ITYPE_IMM       = 3'd1;
    localparam logic [2:0] ITYPE_REG       = 3'd2;
    localparam logic [2:0] ITYPE_SHIFT_LSL = 3'd3;  // LSR/ASR/ROR follow in order

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [63:0] dec_uop;
    logic        dec_legal;
    logic        is_dp;
    logic        dp_ok;
    logic        dst_ok;
    logic [2:0]  shift_type;

    logic accept;
    logic do_write;
    logic do_pop;

    assign instr_ready_o = (count < CNT_W'(DEPTH)) && !rst;
    assign uop_valid_o   = (count != '0);
    assign uop_o         = uop_valid_o ? mem[rd_ptr] : 64'd0;
    assign count_o       = count;

    assign accept   = instr_valid_i && instr_ready_o && !flush_i;
    assign do_write = accept && dec_legal;
    assign do_pop   = uop_valid_o && uop_ready_i && !flush_i;

    // Combinational decode of the fetched word into the FIFO write data.
    always_comb begin
        dec_uop    = 64'd0;
        dec_legal  = 1'b0;
        is_dp      = (instr_i[27:26] == 2'b00);
        // Compare/test opcodes with S=0 are the MSR/hint/misc space, not data processing.
        dp_ok      = !(instr_i[24] && !instr_i[23] && !instr_i[20]);
        // TST/TEQ/CMP/CMN (opcodes 8..11) only set flags.
        dst_ok     = (instr_i[24:23] != 2'b10);
        shift_type = ITYPE_SHIFT_LSL + {1'b0, instr_i[6:5]};

        if (is_dp && !instr_i[25] && instr_i[7] && instr_i[4]) begin
            dec_legal = (MUL_EN != 0);
            dec_uop[UOP_CLASS_LSB +: 3] = CLASS_INTEGER_M;
            dec_uop[UOP_SRC_0_LSB +: 4] = instr_i[3:0];
            dec_uop[UOP_SRC_1_LSB +: 4] = instr_i[11:8];
            dec_uop[UOP_SRC_2_LSB +: 4] = instr_i[15:12];
            dec_uop[UOP_DST_0_LSB +: 4] = instr_i[19:16];
            dec_uop[UOP_DST_0_VALID]    = 1'b1;
        end else if (is_dp && instr_i[25] && dp_ok) begin
            dec_legal = 1'b1;
            dec_uop[UOP_CLASS_LSB  +: 3]  = CLASS_INTEGER;
            dec_uop[UOP_ITYPE_LSB  +: 3]  = ITYPE_IMM;
            dec_uop[UOP_IMM_12_LSB +: 12] = instr_i[11:0];
            dec_uop[UOP_SRC_0_LSB  +: 4]  = instr_i[19:16];
            dec_uop[UOP_DST_0_LSB  +: 4]  = instr_i[15:12];
            dec_uop[UOP_DST_0_VALID]      = dst_ok;
        end else if (is_dp && !instr_i[25] && !instr_i[4] && dp_ok) begin
            dec_legal = 1'b1;
            dec_uop[UOP_SRC_0_LSB +: 4] = instr_i[19:16];
            dec_uop[UOP_SRC_1_LSB +: 4] = instr_i[3:0];
            dec_uop[UOP_DST_0_LSB +: 4] = instr_i[15:12];
            dec_uop[UOP_DST_0_VALID]    = dst_ok;
            // Only an unshifted register operand stays on the simple integer path.
            if (instr_i[6:5] == 2'b00 && instr_i[11:7] == 5'd0) begin
                dec_uop[UOP_CLASS_LSB +: 3] = CLASS_INTEGER;
                dec_uop[UOP_ITYPE_LSB +: 3] = ITYPE_REG;
            end else begin
                dec_uop[UOP_CLASS_LSB +: 3] = CLASS_INTEGER_M;
                dec_uop[UOP_ITYPE_LSB +: 3] = shift_type;
            end
        end else if (is_dp && !instr_i[25] && !instr_i[7] && instr_i[4]) begin
            dec_legal = 1'b1;
            dec_uop[UOP_CLASS_LSB +: 3] = (instr_i[31:28] == 4'hE) ? CLASS_INTEGER_M
                                                                  : CLASS_INTEGER;
            dec_uop[UOP_ITYPE_LSB +: 3] = shift_type;
            dec_uop[UOP_SRC_0_LSB +: 4] = instr_i[19:16];
            dec_uop[UOP_SRC_1_LSB +: 4] = instr_i[3:0];
            dec_uop[UOP_SRC_2_LSB +: 4] = instr_i[11:8];
            dec_uop[UOP_DST_0_LSB +: 4] = instr_i[15:12];
            dec_uop[UOP_DST_0_VALID]    = dst_ok;
        end else if (instr_i[27:26] == 2'b01 && (!instr_i[25] || !instr_i[4])) begin
            dec_legal = 1'b1;
            dec_uop[UOP_CLASS_LSB +: 3] = instr_i[20] ? CLASS_LOAD : CLASS_STORE;
            dec_uop[UOP_SRC_0_LSB +: 4] = instr_i[19:16];
            dec_uop[UOP_DST_0_LSB +: 4] = instr_i[15:12];
            dec_uop[UOP_DST_0_VALID]    = instr_i[20];
        end

        if (dec_legal) begin
            dec_uop[UOP_VALID_B]        = 1'b1;
            dec_uop[UOP_COND_LSB +: 4]  = instr_i[31:28];
        end else begin
            dec_uop = 64'd0;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            mem[wr_ptr] <= dec_uop;
        end
    end

    // Pointers, occupancy and the illegal pulse; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            illegal_o <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            illegal_o <= accept && !dec_legal;
        end
    end

endmodule

// File: tb/tb_uop_decode_queue.sv
// tb/tb_uop_decode_queue.sv - scoreboard bench for uop_decode_queue
module tb_uop_decode_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             flush;
    logic             uop_valid;
    logic             uop_ready;
    logic [63:0]      uop;
    logic [CNT_W-1:0] count;
    logic             illegal;

    logic             nm_valid;
    logic             nm_ready;
    logic             nm_uop_valid;
    logic [63:0]      nm_uop;
    logic [CNT_W-1:0] nm_count;
    logic             nm_illegal;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q[$];
    logic [63:0] cur_uop;
    logic        cur_legal;

    uop_decode_queue #(.DEPTH(DEPTH), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
        .flush_i(flush), .uop_valid_o(uop_valid), .uop_ready_i(uop_ready),
        .uop_o(uop), .count_o(count), .illegal_o(illegal)
    );

    uop_decode_queue #(.DEPTH(DEPTH), .MUL_EN(0)) dut_nm (
        .clk(clk), .rst(rst),
        .instr_valid_i(nm_valid), .instr_ready_o(nm_ready), .instr_i(32'hE0000291),
        .flush_i(1'b0), .uop_valid_o(nm_uop_valid), .uop_ready_i(1'b1),
        .uop_o(nm_uop), .count_o(nm_count), .illegal_o(nm_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected uop builder: class, itype, src0, src1, src2, dst0, dst0_valid, imm12, cond.
    function automatic logic [63:0] mk(input int cls, input int ity, input int s0, input int s1,
                                       input int s2, input int d, input int dv, input int imm,
                                       input int cnd);
        logic [63:0] r;
        r        = 64'd0;
        r[0]     = 1'b1;
        r[4:1]   = cnd[3:0];
        r[7:5]   = cls[2:0];
        r[10:8]  = ity[2:0];
        r[14:11] = s0[3:0];
        r[18:15] = s1[3:0];
        r[22:19] = s2[3:0];
        r[26:23] = d[3:0];
        r[27]    = dv[0];
        r[39:28] = imm[11:0];
        return r;
    endfunction

    // One clock: update the scoreboard from the inputs now applied, then check outputs.
    task automatic step();
        logic acc;
        logic ill_exp;
        logic nm_ill_exp;
        acc        = instr_valid && (exp_q.size() < DEPTH) && !rst && !flush;
        ill_exp    = 1'b0;
        nm_ill_exp = nm_valid && !rst;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (uop_ready && exp_q.size() != 0) begin
                check("pop_uop", uop, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (acc) begin
                if (cur_legal) exp_q.push_back(cur_uop);
                else ill_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("count", 64'(count), 64'(exp_q.size()));
        check("uop_valid", 64'(uop_valid), 64'(exp_q.size() != 0));
        check("instr_ready", 64'(instr_ready), 64'((exp_q.size() < DEPTH) && !rst));
        check("illegal", 64'(illegal), 64'(ill_exp));
        if (exp_q.size() == 0) check("empty_uop", uop, 64'd0);
        else check("head_uop", uop, exp_q[0]);
        check("nm_illegal", 64'(nm_illegal), 64'(nm_ill_exp));
        check("nm_count", 64'(nm_count), 64'd0);
    endtask

    task automatic push(input logic [31:0] w, input logic [63:0] e, input logic legal);
        instr_valid = 1'b1;
        instr       = w;
        cur_uop     = e;
        cur_legal   = legal;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        step();
    endtask

    function automatic logic [31:0] add_imm(input int i);
        return 32'hE2800000 | (32'(i) << 16) | (32'(i) << 12) | 32'(i);
    endfunction

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; flush = 1'b0;
        uop_ready = 1'b1; nm_valid = 1'b0; cur_uop = 64'd0; cur_legal = 1'b0;
        step();
        step();
        rst = 1'b0;

        push(32'hE2811005, mk(1, 1, 1, 0, 0, 1, 1, 5, 14), 1'b1);
        idle();
        push(32'hE3520003, mk(1, 1, 2, 0, 0, 0, 0, 3, 14), 1'b1);
        nm_valid = 1'b1;
        push(32'hE0000291, mk(2, 0, 1, 2, 0, 0, 1, 0, 14), 1'b1);
        nm_valid = 1'b0;
        push(32'hE0812003, mk(1, 2, 1, 3, 0, 2, 1, 0, 14), 1'b1);
        push(32'hE1A01102, mk(2, 3, 0, 2, 0, 1, 1, 0, 14), 1'b1);
        push(32'h10812353, mk(1, 5, 1, 3, 3, 2, 1, 0, 1), 1'b1);
        push(32'hE5910000, mk(3, 0, 1, 0, 0, 0, 1, 0, 14), 1'b1);
        push(32'hE7810002, mk(4, 0, 1, 0, 0, 0, 0, 0, 14), 1'b1);
        push(32'hEA000000, 64'd0, 1'b0);
        idle();
        idle();

        uop_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(add_imm(i), mk(1, 1, i, 0, 0, i, 1, i, 14), 1'b1);
        uop_ready = 1'b1;
        for (int i = 0; i < 5; i++) idle();

        uop_ready = 1'b0;
        for (int i = 7; i <= 10; i++) push(add_imm(i), mk(1, 1, i, 0, 0, i, 1, i, 14), 1'b1);
        uop_ready = 1'b1;
        push(add_imm(11), mk(1, 1, 11, 0, 0, 11, 1, 11, 14), 1'b1);
        push(add_imm(12), mk(1, 1, 12, 0, 0, 12, 1, 12, 14), 1'b1);
        uop_ready = 1'b0;
        flush = 1'b1;
        push(32'hEA000000, 64'd0, 1'b0);
        flush = 1'b0;
        idle();

        push(add_imm(13), mk(1, 1, 13, 0, 0, 13, 1, 13, 14), 1'b1);
        push(add_imm(14), mk(1, 1, 14, 0, 0, 14, 1, 14, 14), 1'b1);
        rst = 1'b1;
        push(add_imm(15), mk(1, 1, 15, 0, 0, 15, 1, 15, 14), 1'b1);
        rst = 1'b0;
        uop_ready = 1'b1;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uop_decode_queue.md
Name: uop_decode_queue

Overview:
Parameterised successor to the single-instruction combinational decoder. It decodes one ARM instruction per cycle into a 64-bit micro-op and buffers decoded uops in a DEPTH-entry FIFO. The FIFO has valid/ready handshakes on both sides, a flush, and an illegal-encoding pulse. It sits between fetch and the issue/rename stage, so a stalled consumer no longer loses fetched instructions.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
MUL_EN, 1, 1 = multiply encodings decode to uops; 0 = multiply encodings reported illegal.
CNT_W, $clog2(DEPTH+1), width of count_o (derived; do not override).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
instr_valid_i  input  1  fetch presents instr_i
instr_ready_o  output  1  queue can accept; equals (count_o < DEPTH) && !rst
instr_i  input  32  instruction word
flush_i  input  1  discard all queued uops and any same-cycle push
uop_valid_o  output  1  head entry valid
uop_ready_i  input  1  consumer takes head this cycle
uop_o  output  64  head uop, field layout per UOP_* macros in micro_operations.v; all-zero when empty
count_o  output  CNT_W  occupancy
illegal_o  output  1  one-cycle pulse: accepted instruction had no legal decode

Behaviour:
- Reset (sync): count_o=0, uop_valid_o=0, uop_o=0, illegal_o=0, read/write pointers=0. FIFO RAM contents are don't-care.
- Push: instr_valid_i && instr_ready_o at edge N, instruction legal -> entry written. It is visible on uop_o with uop_valid_o=1 from cycle N+1 if the queue was empty. No same-cycle bypass.
- Pop: uop_valid_o && uop_ready_i at edge -> head advances. uop_o updates to the next entry, or to 0 if the queue is now empty.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, instr_ready_o=0 even if a pop occurs in the same cycle. There is no ready-through path.
- Pointers wrap modulo DEPTH. count_o never exceeds DEPTH and never underflows.
- flush_i has priority over push and pop. On the next cycle count_o=0 and uop_valid_o=0. A push in the flush cycle is dropped and raises no illegal_o.
- Illegal instruction: accepted (handshake completes), not enqueued, illegal_o=1 for exactly one cycle.
- Every legal uop sets UOP_VALID_B=1 and UOP_COND = instr[31:28]. All unnamed fields are 0.
- Decode priority, first match wins:
  1. Multiply: instr[27:26]=00, [25]=0, [7]=1, [4]=1.
     - Fields: class INTEGER_M, SRC_0=[3:0], SRC_1=[11:8], SRC_2=[15:12].
     - DST_0=[19:16], DST_0_VALID=1.
     - Illegal if MUL_EN=0.
  2. DP immediate: [27:26]=00, [25]=1, and not ([24]=1 && [23]=0 && [20]=0).
     - Fields: class INTEGER, I_TYPE IMM, IMM_12=[11:0], SRC_0=[19:16].
  3. DP register: [27:26]=00, [25]=0, [4]=0, and not ([24]=1 && [23]=0 && [20]=0).
     - Fields: SRC_0=[19:16], SRC_1=[3:0].
     - Shift [6:5]=LSL with [11:7]=0 -> class INTEGER, I_TYPE REG.
     - Any other shift -> class INTEGER_M, I_TYPE = SHIFT_LSL/LSR/ASR/ROR.
  4. Register-shifted register: [27:26]=00, [25]=0, [7]=0, [4]=1.
     - Fields: SRC_0=[19:16], SRC_1=[3:0], SRC_2=[11:8], I_TYPE from [6:5].
     - Class INTEGER_M if cond==AL, else INTEGER.
  5. Load/store word/byte: [27:26]=01, and ([25]=0 or [4]=0).
     - Class LOAD if [20]=1, else STORE.
     - SRC_0=[19:16], DST_0=[15:12].
     - DST_0_VALID = [20].
  6. Everything else is illegal, including hints/MSR and branches.
- Destination rule for cases 2–4: DST_0=[15:12], DST_0_VALID=1 unless opcode [24:21] is TST/TEQ/CMP/CMN (8–11), in which case DST_0_VALID=0.
- The decode path is combinational from instr_i to the FIFO write data. uop_o is driven from a registered head, so there is no combinational path from instr_i to uop_o.

Test Plan:
- Push 0xE2811005 (ADD r1,r1,#5), uop_ready_i=1 -> next cycle uop_valid_o=1, class INTEGER, I_TYPE IMM, IMM_12=0x005, SRC_0=1, DST_0=1, DST_0_VALID=1, COND=0xE.
- Push 0xE3520003 (CMP r2,#3) -> DST_0_VALID=0, SRC_0=2. Push 0xE0000291 (MUL) with MUL_EN=1 -> INTEGER_M, SRC_0=1, SRC_1=2, DST_0=0. Repeat with MUL_EN=0 -> illegal_o one-cycle pulse, count_o unchanged.
- Push 0xE5910000 -> LOAD, DST_0=0, DST_0_VALID=1. Push 0xE7810002 -> STORE, DST_0_VALID=0. Push 0xEA000000 -> illegal_o=1, not enqueued.
- DEPTH=4, uop_ready_i=0, push 6 back-to-back -> count_o reaches 4, instr_ready_o=0. Then drain -> 4 uops emerge in order, pointers wrap, count_o returns to 0, uop_o=0.
- Full queue, simultaneous pop and offered push -> push refused, count_o=3. Next cycle push plus pop -> count_o stays 3.
- Queue holding 3 entries, flush_i=1 with instr_valid_i=1 -> next cycle count_o=0, uop_valid_o=0, no illegal_o. Assert rst mid-stream -> all outputs 0 the following cycle.
